// File: rtl/tlc_pkg.sv
// Shared types and helpers for the adaptive intersection controller.
// Lamp encodings, FSM state enum and the density-based green-time function.
package tlc_pkg;

   localparam logic [2:0] LAMP_RED    = 3'b001;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b100;

   typedef enum logic [1:0] {
      ST_ALL_RED  = 2'd0,
      ST_GREEN    = 2'd1,
      ST_YELLOW   = 2'd2,
      ST_EMG_HOLD = 2'd3
   } tlc_state_e;

   // Green length in cycles, clipped to what a tw-bit timer can hold.
   function automatic int unsigned green_time(
      input int unsigned base,
      input int unsigned step,
      input logic [1:0]  dens,
      input int unsigned tw
   );
      longint unsigned t;
      longint unsigned m;
      t = longint'(base) + longint'(step) * longint'(dens);
      m = (64'd1 << tw) - 64'd1;
      return (t > m) ? 32'(m) : 32'(t);
   endfunction

endpackage

// File: rtl/tlc_next_dir.sv
// Round-robin demand arbiter: first approach after the current one with demand.
// Falls back to current+1 when nobody is asking.
module tlc_next_dir #(
   parameter int NUM_DIR = 4
) (
   input  logic [$clog2(NUM_DIR)-1:0] i_cur_dir,
   input  logic [NUM_DIR-1:0]         i_demand,
   output logic [$clog2(NUM_DIR)-1:0] o_next_dir
);

   localparam int DW = $clog2(NUM_DIR);

   logic w_found;
   int   w_idx;

   always_comb begin
      w_found    = 1'b0;
      w_idx      = 0;
      o_next_dir = DW'((int'(i_cur_dir) + 1) % NUM_DIR);
      for (int k = 1; k <= NUM_DIR; k++) begin
         w_idx = (int'(i_cur_dir) + k) % NUM_DIR;
         if (!w_found && i_demand[w_idx]) begin
            w_found    = 1'b1;
            o_next_dir = DW'(w_idx);
         end
      end
   end

endmodule

// File: rtl/adaptive_intersection_ctrl.sv
// Adaptive traffic-light controller with pedestrian requests and
// emergency preemption; one approach served at a time.
module adaptive_intersection_ctrl
   import tlc_pkg::*;
#(
   parameter int NUM_DIR    = 4,
   parameter int GREEN_BASE = 10,
   parameter int GREEN_STEP = 10,
   parameter int YELLOW_T   = 5,
   parameter int ALLRED_T   = 2,
   parameter int TW         = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [2*NUM_DIR-1:0]       density_i,
   input  logic [NUM_DIR-1:0]         ped_req_i,
   input  logic                       emg_valid_i,
   input  logic [$clog2(NUM_DIR)-1:0] emg_dir_i,
   output logic [3*NUM_DIR-1:0]       lamp_o,
   output logic [NUM_DIR-1:0]         walk_o,
   output logic [$clog2(NUM_DIR)-1:0] cur_dir_o,
   output logic                       emg_active_o
);

   localparam int            DW     = $clog2(NUM_DIR);
   localparam logic [TW-1:0] YEL_LD = TW'(YELLOW_T - 1);
   localparam logic [TW-1:0] AR_LD  = TW'(ALLRED_T - 1);

   tlc_state_e           r_state, w_state_n;
   logic [TW-1:0]        r_timer, w_timer_n;
   logic [DW-1:0]        r_dir, w_dir_n;
   logic                 r_first, w_first_n;
   logic                 r_walk_en, w_walk_en_n;
   logic [NUM_DIR-1:0]   r_pend, w_pend_n;
   logic [3*NUM_DIR-1:0] r_lamp, w_lamp_n;
   logic [NUM_DIR-1:0]   r_walk, w_walk_n;
   logic                 r_emg, w_emg_n;

   logic [NUM_DIR-1:0]   w_demand;
   logic [NUM_DIR-1:0]   w_clr;
   logic [DW-1:0]        w_arb_dir;
   logic [DW-1:0]        w_grn_dir;
   logic [31:0]          w_gt;
   logic                 w_tdone;
   logic                 w_emg_here;

   always_comb begin
      w_demand = '0;
      for (int i = 0; i < NUM_DIR; i++) begin
         w_demand[i] = (density_i[2*i +: 2] != 2'd0) | r_pend[i];
      end
   end

   tlc_next_dir #(
      .NUM_DIR    (NUM_DIR)
   ) u_next_dir (
      .i_cur_dir  (r_dir),
      .i_demand   (w_demand),
      .o_next_dir (w_arb_dir)
   );

   // First green after reset always goes to approach 0.
   assign w_grn_dir  = r_first ? '0 : w_arb_dir;
   assign w_gt       = green_time(GREEN_BASE, GREEN_STEP,
                                  density_i[2*w_grn_dir +: 2], TW);
   assign w_tdone    = (r_timer == '0);
   assign w_emg_here = emg_valid_i && (emg_dir_i == r_dir);

   always_comb begin
      w_state_n   = r_state;
      w_timer_n   = r_timer;
      w_dir_n     = r_dir;
      w_first_n   = r_first;
      w_walk_en_n = r_walk_en;
      w_clr       = '0;
      unique case (r_state)
         ST_ALL_RED: begin
            if (w_tdone) begin
               w_first_n = 1'b0;
               if (emg_valid_i) begin
                  w_state_n   = ST_EMG_HOLD;
                  w_dir_n     = emg_dir_i;
                  w_walk_en_n = 1'b0;
               end else begin
                  w_state_n   = ST_GREEN;
                  w_dir_n     = w_grn_dir;
                  w_timer_n   = (w_gt == 32'd0) ? '0 : TW'(w_gt - 32'd1);
                  w_walk_en_n = r_pend[w_grn_dir];
               end
            end else begin
               w_timer_n = r_timer - TW'(1);
            end
         end
         ST_GREEN: begin
            if (emg_valid_i || w_tdone) begin
               w_clr = NUM_DIR'(1) << r_dir;
               if (w_emg_here) begin
                  w_state_n = ST_EMG_HOLD;
               end else begin
                  w_state_n = ST_YELLOW;
                  w_timer_n = YEL_LD;
               end
            end else begin
               w_timer_n = r_timer - TW'(1);
            end
         end
         ST_YELLOW: begin
            if (w_tdone) begin
               w_state_n = ST_ALL_RED;
               w_timer_n = AR_LD;
            end else begin
               w_timer_n = r_timer - TW'(1);
            end
         end
         ST_EMG_HOLD: begin
            if (!w_emg_here) begin
               w_state_n = ST_YELLOW;
               w_timer_n = YEL_LD;
            end
         end
         default: begin
            w_state_n = ST_ALL_RED;
            w_timer_n = AR_LD;
         end
      endcase

      // A pulse landing on the clear cycle stays pending.
      w_pend_n = (r_pend & ~w_clr) | ped_req_i;

      w_lamp_n = {NUM_DIR{LAMP_RED}};
      w_walk_n = '0;
      w_emg_n  = (w_state_n == ST_EMG_HOLD);
      if (w_state_n == ST_GREEN || w_state_n == ST_EMG_HOLD) begin
         w_lamp_n[3*w_dir_n +: 3] = LAMP_GREEN;
      end else if (w_state_n == ST_YELLOW) begin
         w_lamp_n[3*w_dir_n +: 3] = LAMP_YELLOW;
      end
      if (w_state_n == ST_GREEN && w_walk_en_n) begin
         w_walk_n = NUM_DIR'(1) << w_dir_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_ALL_RED;
         r_timer   <= AR_LD;
         r_dir     <= '0;
         r_first   <= 1'b1;
         r_walk_en <= 1'b0;
         r_pend    <= '0;
         r_lamp    <= {NUM_DIR{LAMP_RED}};
         r_walk    <= '0;
         r_emg     <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_timer   <= w_timer_n;
         r_dir     <= w_dir_n;
         r_first   <= w_first_n;
         r_walk_en <= w_walk_en_n;
         r_pend    <= w_pend_n;
         r_lamp    <= w_lamp_n;
         r_walk    <= w_walk_n;
         r_emg     <= w_emg_n;
      end
   end

   assign lamp_o       = r_lamp;
   assign walk_o       = r_walk;
   assign cur_dir_o    = r_dir;
   assign emg_active_o = r_emg;

endmodule

// File: doc/adaptive_intersection_ctrl.md
ADAPTIVE_INTERSECTION_CTRL -- requirements
Module: adaptive_intersection_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIR, default 4, number of approaches (legal 2..8).
REQ-002 SHALL have parameter GREEN_BASE, default 10, green cycles at density 0.
REQ-003 SHALL have parameter GREEN_STEP, default 10, extra green cycles per density unit.
REQ-004 SHALL have parameter YELLOW_T, default 5, yellow cycles; ALLRED_T, default 2, all-red clearance cycles; TW, default 8, timer width.
REQ-005 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have density_i  input  2*NUM_DIR  per-approach density 0..3, slice i = approach i.
REQ-008 SHALL have ped_req_i  input  NUM_DIR  one-cycle pedestrian request pulses.
REQ-009 SHALL have emg_valid_i  input  1  emergency preemption request (level).
REQ-010 SHALL have emg_dir_i  input  $clog2(NUM_DIR)  emergency approach index.
REQ-011 SHALL have lamp_o  output  3*NUM_DIR  per-approach lamp, RED=001, YELLOW=010, GREEN=100.
REQ-012 SHALL have walk_o  output  NUM_DIR  pedestrian walk per approach.
REQ-013 SHALL have cur_dir_o  output  $clog2(NUM_DIR)  approach currently served; emg_active_o  output  1  high in EMG_HOLD.

Function
REQ-014 SHALL implement states ALL_RED, GREEN, YELLOW, EMG_HOLD; every non-served approach RED in all states.
REQ-015 SHALL load timer with duration-1 on state entry, decrement each cycle, leave state when timer=0; each state lasts exactly its duration.
REQ-016 SHALL compute green duration = GREEN_BASE + GREEN_STEP*density of the served approach, sampled once on GREEN entry, width TW, saturating at 2^TW-1.
REQ-017 SHALL sequence GREEN -> YELLOW -> ALL_RED -> GREEN(next).
REQ-018 SHALL select next = first index after cur_dir (mod NUM_DIR) with demand (density!=0 or ped pending); if none, cur_dir+1 mod NUM_DIR.
REQ-019 SHALL latch ped_req_i[i] into pending[i]; clear pending[i] on exit from GREEN of i; a new pulse on the clear cycle wins (remains pending).
REQ-020 SHALL drive walk_o[i]=1 only in GREEN of i when pending[i] was set at GREEN entry; 0 in YELLOW, ALL_RED, EMG_HOLD.
REQ-021 SHALL on emg_valid_i in GREEN of another approach go to YELLOW (full YELLOW_T), ALL_RED, then EMG_HOLD on emg_dir_i sampled at EMG_HOLD entry.
REQ-022 SHALL on emg_valid_i in GREEN of emg_dir_i enter EMG_HOLD next cycle, no yellow.
REQ-023 SHALL on emg_valid_i in YELLOW or ALL_RED complete that state, then enter EMG_HOLD (skip normal GREEN).
REQ-024 SHALL in EMG_HOLD hold emg dir GREEN untimed; on emg_valid_i drop or emg_dir_i change go YELLOW -> ALL_RED, then EMG_HOLD on new dir if still valid, else GREEN of next per REQ-018.
REQ-025 SHALL never show GREEN or YELLOW on two approaches simultaneously.

Reset
REQ-026 SHALL on rst_n=0 at a clock edge set state ALL_RED with timer ALLRED_T-1, cur_dir 0, pending all 0.
REQ-027 SHALL give reset outputs: lamp_o all RED, walk_o 0, cur_dir_o 0, emg_active_o 0.
REQ-028 SHALL after reset serve approach 0 first regardless of demand; reset mid-operation aborts any state including EMG_HOLD.

Structure
REQ-029 SHALL place lamp encodings, state enum and green-time function in shared package tlc_pkg.
REQ-030 SHALL use one sub-module, tlc_next_dir, a combinational round-robin demand arbiter.

Verification (NUM_DIR=4, defaults)
REQ-031 SHALL test reset release, all densities 1: 2 all-red cycles, dir0 GREEN 20, YELLOW 5, ALL_RED 2, dir1 GREEN.
REQ-032 SHALL test skip: densities {1,0,0,2}, no peds: after dir0, dir3 GREEN for 30 cycles.
REQ-033 SHALL test ped pulse on dir2 during dir0 GREEN, density2=0: dir2 served 10 cycles, walk_o[2]=1 throughout, pending cleared.
REQ-034 SHALL test emg_dir=2 mid dir0 GREEN: dir0 YELLOW 5, ALL_RED 2, dir2 GREEN, emg_active_o=1; drop: dir2 YELLOW 5, ALL_RED 2, dir3 GREEN if demand.
REQ-035 SHALL test emg_dir equal to current green dir: EMG_HOLD next cycle, no yellow, walk_o all 0.
REQ-036 SHALL test rst_n low mid-YELLOW and mid-EMG_HOLD: next cycle all RED, walk 0, pending 0.
